// File: rtl/am2901_useq_if.sv
// Host/control-store/slice bundle for the am2901_useq microprogram sequencer.
// master: host + control store + slice status side; slave: the sequencer.
interface am2901_useq_if #(
  parameter int UADDR_W = 6
);
  localparam int UW = 28 + UADDR_W;

  logic               start;
  logic [UADDR_W-1:0] start_addr;
  logic               busy;
  logic               done;
  logic               err;

  logic [UADDR_W-1:0] uaddr;
  logic [UW-1:0]      uword;

  logic               z;
  logic               cout;
  logic               ovr;
  logic               f3;

  logic [8:0]         am_i;
  logic [3:0]         am_a;
  logic [3:0]         am_b;
  logic [3:0]         am_d;
  logic               am_cin;

  modport master (
    output start, start_addr, uword, z, cout, ovr, f3,
    input  busy, done, err, uaddr, am_i, am_a, am_b, am_d, am_cin
  );

  modport slave (
    input  start, start_addr, uword, z, cout, ovr, f3,
    output busy, done, err, uaddr, am_i, am_a, am_b, am_d, am_cin
  );
endinterface

// File: rtl/am2901_useq.sv
// Microprogram sequencer for one Am2901 slice: branches, calls, counted loops.
// Optional loop counter (LDCT/RPCT) enabled by defining SEQ_LOOP_CTR_EN.
//
//  state  | meaning
//  IDLE   | waiting for start; slice gets NOP
//  RUN    | executing the microword at upc each cycle
//  DONE   | one-cycle done pulse, then back to IDLE
module am2901_useq #(
  parameter int         UADDR_W = 6,
  parameter int         STACK_D = 4,
  parameter int         CTR_W   = 8,
  parameter logic [8:0] NOP_I   = 9'h044
) (
  input  logic         cp,
  input  logic         rst_lo,
  am2901_useq_if.slave bus
);
  localparam int UW    = 28 + UADDR_W;
  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  localparam logic [2:0] OP_CONT  = 3'd0;
  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_JCOND = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_LDCT  = 3'd5;
  localparam logic [2:0] OP_RPCT  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               err_q, err_d;
  logic [UADDR_W-1:0] stack_q [STACK_D];
  logic [UADDR_W-1:0] stack_d [STACK_D];
`ifdef SEQ_LOOP_CTR_EN
  logic [CTR_W-1:0]   ctr_q, ctr_d;
`endif

  logic [8:0]         f_i;
  logic [3:0]         f_a;
  logic [3:0]         f_b;
  logic [3:0]         f_d;
  logic               f_cin;
  logic [2:0]         f_op;
  logic [2:0]         f_cond;
  logic [UADDR_W-1:0] f_tgt;

  assign f_i    = bus.uword[8:0];
  assign f_a    = bus.uword[12:9];
  assign f_b    = bus.uword[16:13];
  assign f_d    = bus.uword[20:17];
  assign f_cin  = bus.uword[21];
  assign f_op   = bus.uword[24:22];
  assign f_cond = bus.uword[27:25];
  assign f_tgt  = bus.uword[UW-1:28];

  logic               flag_sel;
  logic               cond_true;
  logic [UADDR_W-1:0] upc_inc;
  logic [SP_W-1:0]    sp_dec;
  logic               stack_full;
  logic               stack_empty;

  // Low two cond bits pick the flag, the top bit inverts it.
  always_comb begin
    flag_sel = 1'b0;
    case (f_cond[1:0])
      2'd0:    flag_sel = bus.z;
      2'd1:    flag_sel = bus.cout;
      2'd2:    flag_sel = bus.ovr;
      default: flag_sel = bus.f3;
    endcase
  end

  assign cond_true   = flag_sel ^ f_cond[2];
  assign upc_inc     = upc_q + UADDR_W'(1);
  assign sp_dec      = sp_q - SP_W'(1);
  assign stack_full  = (sp_q == SP_W'(STACK_D));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
`ifdef SEQ_LOOP_CTR_EN
    ctr_d   = ctr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          upc_d   = bus.start_addr;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        case (f_op)
          OP_JMP:   upc_d = f_tgt;
          OP_JCOND: upc_d = cond_true ? f_tgt : upc_inc;
          OP_CALL: begin
            if (stack_full) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              stack_d[sp_q[IDX_W-1:0]] = upc_inc;
              sp_d  = sp_q + SP_W'(1);
              upc_d = f_tgt;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              upc_d = stack_q[sp_dec[IDX_W-1:0]];
              sp_d  = sp_dec;
            end
          end
`ifdef SEQ_LOOP_CTR_EN
          OP_LDCT: begin
            ctr_d = CTR_W'(f_tgt);
            upc_d = upc_inc;
          end
          OP_RPCT: begin
            if (ctr_q != '0) begin
              ctr_d = ctr_q - CTR_W'(1);
              upc_d = f_tgt;
            end else begin
              upc_d = upc_inc;
            end
          end
`endif
          OP_HALT:  state_d = S_DONE;
          // CONT, plus LDCT/RPCT when the loop counter is compiled out
          default:  upc_d = upc_inc;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cp) begin
    stack_q <= stack_d;
    if (!rst_lo) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
`ifdef SEQ_LOOP_CTR_EN
      ctr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
`ifdef SEQ_LOOP_CTR_EN
      ctr_q   <= ctr_d;
`endif
    end
  end

  logic run;
  assign run = (state_q == S_RUN);

  assign bus.busy   = run;
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;
  assign bus.uaddr  = upc_q;
  assign bus.am_i   = run ? f_i   : NOP_I;
  assign bus.am_a   = run ? f_a   : 4'd0;
  assign bus.am_b   = run ? f_b   : 4'd0;
  assign bus.am_d   = run ? f_d   : 4'd0;
  assign bus.am_cin = run ? f_cin : 1'b0;
endmodule

// File: tb/tb_am2901_useq.sv
// Bench for am2901_useq: directed microprograms with literal traces plus
// randomized control stores checked every cycle against a behavioural model.
module tb_am2901_useq;
  localparam int UADDR_W = 6;
  localparam int UW      = 28 + UADDR_W;
  localparam int STACK_D = 4;
  localparam int NWORDS  = 64;

  logic cp = 1'b0;
  logic rst_lo = 1'b0;
  am2901_useq_if #(.UADDR_W(UADDR_W)) bus ();
  logic [UW-1:0] rom [NWORDS];

  assign bus.uword = rom[bus.uaddr];

  am2901_useq #(
    .UADDR_W(UADDR_W), .STACK_D(STACK_D), .CTR_W(8), .NOP_I(9'h044)
  ) dut (
    .cp(cp), .rst_lo(rst_lo), .bus(bus.slave)
  );

  always #5 cp = ~cp;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 running, 2 finishing
  int m_mode = 0;
  int m_upc = 0;
  int m_ctr = 0;
  bit m_err = 1'b0;
  int m_stack[$];

  function automatic logic [UW-1:0] mk(input int op, input int cnd, input int tgt);
    logic [UW-1:0] w;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    w = r[UW-1:0];
    w[24:22] = op[2:0];
    w[27:25] = cnd[2:0];
    w[UW-1:28] = tgt[UADDR_W-1:0];
    return w;
  endfunction

  always @(posedge cp) begin
    logic [UW-1:0] w;
    int op, cnd, tgt, nxt;
    bit fl;
    if (!rst_lo) begin
      m_mode = 0; m_upc = 0; m_ctr = 0; m_err = 1'b0; m_stack.delete();
    end else if (m_mode == 0) begin
      if (bus.start) begin
        m_mode = 1; m_upc = int'(bus.start_addr); m_err = 1'b0; m_stack.delete();
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else begin
      w   = rom[m_upc];
      op  = int'(w[24:22]);
      cnd = int'(w[27:25]);
      tgt = int'(w[UW-1:28]);
      nxt = (m_upc + 1) % NWORDS;
      case (cnd % 4)
        0: fl = bus.z;
        1: fl = bus.cout;
        2: fl = bus.ovr;
        default: fl = bus.f3;
      endcase
      if (cnd >= 4) fl = !fl;
      case (op)
        1: m_upc = tgt;
        2: m_upc = fl ? tgt : nxt;
        3: begin
          if (m_stack.size() == STACK_D) begin m_err = 1'b1; m_mode = 2; end
          else begin m_stack.push_back(nxt); m_upc = tgt; end
        end
        4: begin
          if (m_stack.size() == 0) begin m_err = 1'b1; m_mode = 2; end
          else m_upc = m_stack.pop_back();
        end
`ifdef SEQ_LOOP_CTR_EN
        5: begin m_ctr = tgt % 256; m_upc = nxt; end
        6: begin
          if (m_ctr != 0) begin m_ctr = m_ctr - 1; m_upc = tgt; end
          else m_upc = nxt;
        end
`endif
        7: m_mode = 2;
        default: m_upc = nxt;
      endcase
    end
  end

  always @(negedge cp) begin
    logic [UW-1:0] w;
    logic [8:0] exp_ctl, act_ctl;
    logic [21:0] exp_sl, act_sl;
    if (chk_en) begin
      w = rom[m_upc];
      exp_ctl = {m_mode == 1, m_mode == 2, m_err, 6'(m_upc)};
      act_ctl = {bus.busy, bus.done, bus.err, bus.uaddr};
      checks++;
      if (act_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl t=%0t busy/done/err/uaddr got=%h want=%h", $time, act_ctl, exp_ctl);
      end
      exp_sl = (m_mode == 1) ? {w[8:0], w[12:9], w[16:13], w[20:17], w[21]} : {9'h044, 13'd0};
      act_sl = {bus.am_i, bus.am_a, bus.am_b, bus.am_d, bus.am_cin};
      checks++;
      if (act_sl !== exp_sl) begin
        failures++;
        $display("FAIL slice t=%0t am_* got=%h want=%h", $time, act_sl, exp_sl);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic check_s(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=\"%s\" want=\"%s\"", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge cp);
    #1;
  endtask

  string trace;
  int done_cyc;
  int busy_n;
  int err_at_done;

  task automatic run_prog(input int a, input int maxc);
    trace = "";
    done_cyc = -1;
    busy_n = 0;
    err_at_done = 0;
    tick();
    bus.start = 1'b1;
    bus.start_addr = a[UADDR_W-1:0];
    @(posedge cp);
    for (int n = 1; n <= maxc; n++) begin
      @(negedge cp);
      if (bus.busy) begin
        trace = (trace == "") ? $sformatf("%0d", bus.uaddr) : $sformatf("%s %0d", trace, bus.uaddr);
        busy_n++;
      end
      if (bus.done) begin
        done_cyc = n;
        err_at_done = int'(bus.err);
        break;
      end
      #1;
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout start_addr=%0d no done within %0d cycles", a, maxc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) rom[i] = mk(7, 0, 0);
    bus.start = 1'b0; bus.start_addr = '0;
    bus.z = 1'b0; bus.cout = 1'b0; bus.ovr = 1'b0; bus.f3 = 1'b0;
    rst_lo = 1'b0;
    repeat (2) @(posedge cp);
    @(negedge cp);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_uaddr", int'(bus.uaddr), 0);
    check("rst_am_i", int'(bus.am_i), 'h044);
    #1;
    rst_lo = 1'b1;
    chk_en = 1'b1;

    // straight-line routine and its latency
    rom[5] = mk(0, 0, 0); rom[6] = mk(0, 0, 0); rom[7] = mk(7, 0, 0);
    run_prog(5, 20);
    check_s("cont_trace", trace, "5 6 7");
    check("cont_done_cycle", done_cyc, 4);
    check("cont_busy_cycles", busy_n, 3);

    // conditional branch, plain and inverted
    rom[2] = mk(2, 0, 9); rom[9] = mk(7, 0, 0); rom[3] = mk(7, 0, 0);
    bus.z = 1'b1;
    run_prog(2, 20);
    check_s("jcond_z1", trace, "2 9");
    bus.z = 1'b0;
    run_prog(2, 20);
    check_s("jcond_z0", trace, "2 3");
    rom[2] = mk(2, 4, 9);
    run_prog(2, 20);
    check_s("jcond_inv_z0", trace, "2 9");
    rom[2] = mk(2, 1, 9);
    bus.cout = 1'b1;
    run_prog(2, 20);
    check_s("jcond_cout1", trace, "2 9");
    bus.cout = 1'b0;

    // call / return, then stack overflow
    rom[0] = mk(3, 0, 20); rom[20] = mk(4, 0, 0); rom[1] = mk(7, 0, 0);
    run_prog(0, 20);
    check_s("call_ret_trace", trace, "0 20 1");
    check("call_ret_err", err_at_done, 0);
    for (int i = 0; i < 5; i++) rom[i] = mk(3, 0, i + 1);
    run_prog(0, 20);
    check_s("overflow_trace", trace, "0 1 2 3 4");
    check("overflow_err", err_at_done, 1);
    check("overflow_done_cycle", done_cyc, 6);

    // counted loop; err from the previous routine cleared by this start
    rom[0] = mk(5, 0, 3); rom[1] = mk(6, 0, 1); rom[2] = mk(7, 0, 0);
    run_prog(0, 30);
`ifdef SEQ_LOOP_CTR_EN
    check_s("loop_trace", trace, "0 1 1 1 1 2");
`else
    check_s("loop_trace", trace, "0 1 2");
`endif
    check("loop_err_cleared", err_at_done, 0);

    // address wrap and return on empty stack
    rom[63] = mk(0, 0, 0); rom[0] = mk(7, 0, 0);
    run_prog(63, 20);
    check_s("wrap_trace", trace, "63 0");
    rom[8] = mk(4, 0, 0);
    run_prog(8, 20);
    check_s("ret_empty_trace", trace, "8");
    check("ret_empty_err", err_at_done, 1);
    check("ret_empty_done_cycle", done_cyc, 2);

    // start ignored while busy, reset aborts a running routine
    rom[10] = mk(1, 0, 10);
    tick();
    bus.start = 1'b1; bus.start_addr = 6'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1; bus.start_addr = 6'd5;
    tick();
    check("busy_start_ignored_uaddr", int'(bus.uaddr), 10);
    check("busy_start_ignored_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    rst_lo = 1'b0;
    @(negedge cp);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_am_i", int'(bus.am_i), 'h044);
    check("abort_uaddr", int'(bus.uaddr), 0);
    check("abort_done", int'(bus.done), 0);
    #1;
    rst_lo = 1'b1;

    // randomized control stores
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < NWORDS; i++) begin
        int r, op;
        r = int'($urandom_range(0, 15));
        if (r < 5) op = 0;
        else if (r < 6) op = 1;
        else if (r < 8) op = 2;
        else if (r < 9) op = 3;
        else if (r < 10) op = 4;
        else if (r < 11) op = 5;
        else if (r < 12) op = 6;
        else op = 7;
        rom[i] = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, NWORDS - 1)));
        if (op == 5) rom[i][UW-1:28] = 6'($urandom_range(0, 5));
      end
      for (int c = 0; c < 400; c++) begin
        tick();
        bus.z = 1'($urandom); bus.cout = 1'($urandom);
        bus.ovr = 1'($urandom); bus.f3 = 1'($urandom);
        bus.start = ($urandom_range(0, 3) == 0);
        bus.start_addr = 6'($urandom);
        rst_lo = ($urandom_range(0, 149) != 0);
      end
    end
    tick();
    bus.start = 1'b0;
    rst_lo = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
